// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, sequencer states and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SUMA  = 4'd0,
        OP_RESTA = 4'd1,
        OP_MULT  = 4'd2,
        OP_DIV   = 4'd3,
        OP_MOD   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        INACTIVO,
        ESPERA,
        RESPUESTA
    } estado_e;

    localparam int unsigned BANDERA_NEGATIVO = 3;
    localparam int unsigned BANDERA_CERO     = 2;
    localparam int unsigned BANDERA_ACARREO  = 1;
    localparam int unsigned BANDERA_DESBORDE = 0;

    localparam logic [3:0] OPCODE_MAX = 4'd9;

endpackage

// File: rtl/validador_comando.sv
// Combinational screen for commands the ALU must never see: undefined opcodes and x/0, x%0.
module validador_comando
    import alu_pkg::*;
#(
    parameter int unsigned ancho = 3
) (
    input  logic [3:0]     i_seleccion,
    input  logic [ancho:0] i_operandoB,
    output logic           o_invalido
);

    logic w_es_division;

    always_comb begin
        w_es_division = (i_seleccion == 4'(OP_DIV)) || (i_seleccion == 4'(OP_MOD));
        o_invalido    = (i_seleccion > OPCODE_MAX) || (w_es_division && (i_operandoB == '0));
    end

endmodule

// File: rtl/controlador_alu.sv
// Valid/ready sequencer driving a combinational ALU, waiting LATENCIA cycles, returning the result.
// Define ALU_ACUMULADOR_EN to add an accumulator that can replace operand A.
module controlador_alu
    import alu_pkg::*;
#(
    parameter int unsigned ancho    = 3,
    parameter int unsigned LATENCIA = 1
) (
    input  logic           reloj,
    input  logic           reset,
    input  logic           cmd_valido,
    output logic           cmd_listo,
    input  logic [3:0]     cmd_seleccion,
    input  logic [ancho:0] cmd_operandoA,
    input  logic [ancho:0] cmd_operandoB,
`ifdef ALU_ACUMULADOR_EN
    input  logic           cmd_usar_acumulador,
`endif
    output logic [ancho:0] alu_operandoA,
    output logic [ancho:0] alu_operandoB,
    output logic [3:0]     alu_seleccion,
    input  logic [ancho:0] alu_resultado,
    input  logic [3:0]     alu_banderas,
    output logic           rsp_valido,
    input  logic           rsp_listo,
    output logic [ancho:0] rsp_resultado,
    output logic [3:0]     rsp_banderas,
    output logic           rsp_error,
    output logic           ocupado
);

    if (LATENCIA < 1) begin : g_latencia_invalida
        $error("controlador_alu: LATENCIA must be at least 1");
    end

    localparam int unsigned CW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;

    estado_e        r_estado;
    estado_e        w_estado_d;
    logic [CW-1:0]  r_cuenta;
    logic [ancho:0] r_alu_a;
    logic [ancho:0] r_alu_b;
    logic [3:0]     r_alu_sel;
    logic [ancho:0] r_rsp_res;
    logic [3:0]     r_rsp_ban;
    logic           r_rsp_err;
    logic           w_invalido;
    logic           w_acepta;
    logic           w_captura;
    logic [ancho:0] w_operandoA;

`ifdef ALU_ACUMULADOR_EN
    logic [ancho:0] r_acumulador;
    assign w_operandoA = cmd_usar_acumulador ? r_acumulador : cmd_operandoA;
`else
    assign w_operandoA = cmd_operandoA;
`endif

    validador_comando #(
        .ancho (ancho)
    ) u_validador (
        .i_seleccion (cmd_seleccion),
        .i_operandoB (cmd_operandoB),
        .o_invalido  (w_invalido)
    );

    assign w_acepta  = (r_estado == INACTIVO) && cmd_valido;
    assign w_captura = (r_estado == ESPERA) && (r_cuenta == '0);

    always_comb begin
        w_estado_d = r_estado;
        unique case (r_estado)
            INACTIVO:  if (cmd_valido) w_estado_d = w_invalido ? RESPUESTA : ESPERA;
            ESPERA:    if (r_cuenta == '0) w_estado_d = RESPUESTA;
            RESPUESTA: if (rsp_listo) w_estado_d = INACTIVO;
            default:   w_estado_d = INACTIVO;
        endcase
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            r_estado <= INACTIVO;
        end else begin
            r_estado <= w_estado_d;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            r_cuenta  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_rsp_res <= '0;
            r_rsp_ban <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            // Rejected commands leave the ALU drive untouched.
            if (w_acepta && !w_invalido) begin
                r_alu_a   <= w_operandoA;
                r_alu_b   <= cmd_operandoB;
                r_alu_sel <= cmd_seleccion;
                r_cuenta  <= CW'(LATENCIA - 1);
            end else if ((r_estado == ESPERA) && (r_cuenta != '0)) begin
                r_cuenta <= r_cuenta - CW'(1);
            end

            if (w_acepta && w_invalido) begin
                r_rsp_res <= '0;
                r_rsp_ban <= '0;
                r_rsp_err <= 1'b1;
            end else if (w_captura) begin
                r_rsp_res <= alu_resultado;
                r_rsp_ban <= alu_banderas;
                r_rsp_err <= 1'b0;
            end
        end
    end

`ifdef ALU_ACUMULADOR_EN
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            r_acumulador <= '0;
        end else if (w_captura) begin
            r_acumulador <= alu_resultado;
        end
    end
`endif

    assign cmd_listo     = (r_estado == INACTIVO);
    assign ocupado       = (r_estado != INACTIVO);
    assign rsp_valido    = (r_estado == RESPUESTA);
    assign alu_operandoA = r_alu_a;
    assign alu_operandoB = r_alu_b;
    assign alu_seleccion = r_alu_sel;
    assign rsp_resultado = r_rsp_res;
    assign rsp_banderas  = r_rsp_ban;
    assign rsp_error     = r_rsp_err;

endmodule

// File: tb/tb_controlador_alu.sv
// Bench for controlador_alu: two instances (LATENCIA 1 and 3) with a behavioural ALU and command model.
module tb_controlador_alu;

    localparam int W = 4;

    logic reloj = 1'b0;
    always #5 reloj = ~reloj;

    logic         reset      [2];
    logic         cmd_valido [2];
    logic         cmd_listo  [2];
    logic [3:0]   cmd_sel    [2];
    logic [W-1:0] cmd_a      [2];
    logic [W-1:0] cmd_b      [2];
    logic         usar_acc   [2];
    logic [W-1:0] alu_a      [2];
    logic [W-1:0] alu_b      [2];
    logic [3:0]   alu_sel    [2];
    logic [W-1:0] alu_res    [2];
    logic [3:0]   alu_flg    [2];
    logic         rsp_valido [2];
    logic         rsp_listo  [2];
    logic [W-1:0] rsp_res    [2];
    logic [3:0]   rsp_flg    [2];
    logic         rsp_err    [2];
    logic         ocupado    [2];

    logic [3:0]   exp_sel [2];
    logic [W-1:0] exp_a   [2];
    logic [W-1:0] exp_b   [2];
    logic [W-1:0] exp_acc [2];

    int total = 0;
    int bad   = 0;

    // ALU behaviour: flags are {negative, zero, carry/borrow/overflow-out, 0}.
    function automatic logic [W+3:0] alu_ref(input logic [3:0] s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int p;
        logic [W-1:0] r;
        case (s)
            4'd0:    p = int'(a) + int'(b);
            4'd1:    p = int'(a) - int'(b);
            4'd2:    p = int'(a) * int'(b);
            4'd3:    p = (b != 0) ? int'(a) / int'(b) : 0;
            4'd4:    p = (b != 0) ? int'(a) % int'(b) : 0;
            4'd5:    p = int'(a & b);
            4'd6:    p = int'(a | b);
            4'd7:    p = int'(a ^ b);
            4'd8:    p = int'(a) << b;
            4'd9:    p = int'(a) >> b;
            default: p = 0;
        endcase
        r = p[W-1:0];
        return {r[W-1], (r == '0), (p < 0 || p > 15), 1'b0, r};
    endfunction

    assign {alu_flg[0], alu_res[0]} = alu_ref(alu_sel[0], alu_a[0], alu_b[0]);
    assign {alu_flg[1], alu_res[1]} = alu_ref(alu_sel[1], alu_a[1], alu_b[1]);

    controlador_alu #(.ancho(W - 1), .LATENCIA(1)) u_lat1 (
        .reloj(reloj), .reset(reset[0]), .cmd_valido(cmd_valido[0]), .cmd_listo(cmd_listo[0]),
        .cmd_seleccion(cmd_sel[0]), .cmd_operandoA(cmd_a[0]), .cmd_operandoB(cmd_b[0]),
`ifdef ALU_ACUMULADOR_EN
        .cmd_usar_acumulador(usar_acc[0]),
`endif
        .alu_operandoA(alu_a[0]), .alu_operandoB(alu_b[0]), .alu_seleccion(alu_sel[0]),
        .alu_resultado(alu_res[0]), .alu_banderas(alu_flg[0]), .rsp_valido(rsp_valido[0]),
        .rsp_listo(rsp_listo[0]), .rsp_resultado(rsp_res[0]), .rsp_banderas(rsp_flg[0]),
        .rsp_error(rsp_err[0]), .ocupado(ocupado[0])
    );

    controlador_alu #(.ancho(W - 1), .LATENCIA(3)) u_lat3 (
        .reloj(reloj), .reset(reset[1]), .cmd_valido(cmd_valido[1]), .cmd_listo(cmd_listo[1]),
        .cmd_seleccion(cmd_sel[1]), .cmd_operandoA(cmd_a[1]), .cmd_operandoB(cmd_b[1]),
`ifdef ALU_ACUMULADOR_EN
        .cmd_usar_acumulador(usar_acc[1]),
`endif
        .alu_operandoA(alu_a[1]), .alu_operandoB(alu_b[1]), .alu_seleccion(alu_sel[1]),
        .alu_resultado(alu_res[1]), .alu_banderas(alu_flg[1]), .rsp_valido(rsp_valido[1]),
        .rsp_listo(rsp_listo[1]), .rsp_resultado(rsp_res[1]), .rsp_banderas(rsp_flg[1]),
        .rsp_error(rsp_err[1]), .ocupado(ocupado[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_alu(input int d, input string tag);
        chk({tag, "_alu_sel"}, alu_sel[d], exp_sel[d]);
        chk({tag, "_alu_a"}, alu_a[d], exp_a[d]);
        chk({tag, "_alu_b"}, alu_b[d], exp_b[d]);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_cmd_listo", cmd_listo[d], 1);
        chk("rst_ocupado", ocupado[d], 0);
        chk("rst_rsp_valido", rsp_valido[d], 0);
        chk("rst_rsp_res", rsp_res[d], 0);
        chk("rst_rsp_flg", rsp_flg[d], 0);
        chk("rst_rsp_err", rsp_err[d], 0);
        chk("rst_alu_sel", alu_sel[d], 0);
        chk("rst_alu_a", alu_a[d], 0);
        chk("rst_alu_b", alu_b[d], 0);
    endtask

    // Called right after the accepting edge; lat = further edges until rsp_valido is seen.
    task automatic wait_rsp(input int d, input int lat);
        int n = 0;
        while (rsp_valido[d] !== 1'b1 && n < 20) begin
            chk("espera_ocupado", ocupado[d], 1);
            chk("espera_cmd_listo", cmd_listo[d], 0);
            chk_alu(d, "espera");
            tick();
            n++;
        end
        chk("latencia", n, lat);
    endtask

    task automatic check_rsp(input int d, input logic [W-1:0] res, input logic [3:0] flg,
                             input logic err, input int hold, input bit previo);
        chk("rsp_valido", rsp_valido[d], 1);
        chk("rsp_res", rsp_res[d], res);
        chk("rsp_flg", rsp_flg[d], flg);
        chk("rsp_err", rsp_err[d], err);
        chk("rsp_ocupado", ocupado[d], 1);
        chk("rsp_cmd_listo", cmd_listo[d], 0);
        chk_alu(d, "rsp");
        if (!previo) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valido", rsp_valido[d], 1);
                chk("hold_res", rsp_res[d], res);
                chk("hold_err", rsp_err[d], err);
                chk("hold_cmd_listo", cmd_listo[d], 0);
            end
            rsp_listo[d] = 1'b1;
        end
        tick();
        chk("fin_valido", rsp_valido[d], 0);
        chk("fin_ocupado", ocupado[d], 0);
        chk("fin_cmd_listo", cmd_listo[d], 1);
        rsp_listo[d] = 1'b0;
    endtask

    task automatic run_cmd(input int d, input logic [3:0] s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit usa, input int hold, input bit previo);
        logic [W-1:0] aeff;
        logic         inv;
        logic [W+3:0] r;
        chk("idle_cmd_listo", cmd_listo[d], 1);
        aeff = usa ? exp_acc[d] : a;
        inv  = (s > 4'd9) || (((s == 4'd3) || (s == 4'd4)) && (b == '0));
        rsp_listo[d]  = previo;
        cmd_valido[d] = 1'b1;
        cmd_sel[d]    = s;
        cmd_a[d]      = a;
        cmd_b[d]      = b;
        usar_acc[d]   = usa;
        tick();
        cmd_valido[d] = 1'b0;
        usar_acc[d]   = 1'b0;
        r = '0;
        if (!inv) begin
            exp_sel[d] = s;
            exp_a[d]   = aeff;
            exp_b[d]   = b;
            r          = alu_ref(s, aeff, b);
        end
        // A rejected command goes straight to the response at the accepting edge.
        wait_rsp(d, inv ? 0 : lat_of(d));
        check_rsp(d, r[W-1:0], r[W+3:W], inv, hold, previo);
        if (!inv) exp_acc[d] = r[W-1:0];
    endtask

    initial begin
        logic [W+3:0] r;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; cmd_valido[d] = 1'b0; cmd_sel[d] = '0; cmd_a[d] = '0;
            cmd_b[d] = '0; usar_acc[d] = 1'b0; rsp_listo[d] = 1'b0;
            exp_sel[d] = '0; exp_a[d] = '0; exp_b[d] = '0; exp_acc[d] = '0;
        end
        tick();
        tick();
        chk_reset(0);
        chk_reset(1);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick();

        // Addition 5+3 on the single-cycle instance.
        run_cmd(0, 4'd0, 4'd5, 4'd3, 1'b0, 1, 1'b0);
        chk("t1_res", rsp_res[0], 8);
        chk("t1_flg", rsp_flg[0], 4'b1000);

        // Divide by zero is rejected and leaves the ALU drive alone.
        run_cmd(0, 4'd3, 4'd9, 4'd0, 1'b0, 0, 1'b0);
        chk("t2_err", rsp_err[0], 1);
        chk("t2_alu_sel", alu_sel[0], 0);
        chk("t2_alu_a", alu_a[0], 5);
        chk("t2_alu_b", alu_b[0], 3);

        // Undefined opcode.
        run_cmd(0, 4'd12, 4'd1, 4'd1, 1'b0, 2, 1'b0);
        chk("t3_err", rsp_err[0], 1);

        // Stalled response with a second command waiting the whole time.
        rsp_listo[1]  = 1'b0;
        cmd_valido[1] = 1'b1;
        cmd_sel[1] = 4'd1; cmd_a[1] = 4'd7; cmd_b[1] = 4'd2;
        tick();
        exp_sel[1] = 4'd1; exp_a[1] = 4'd7; exp_b[1] = 4'd2;
        cmd_sel[1] = 4'd6; cmd_a[1] = 4'd4; cmd_b[1] = 4'd9;
        wait_rsp(1, 3);
        r = alu_ref(4'd1, 4'd7, 4'd2);
        check_rsp(1, 4'd5, r[W+3:W], 1'b0, 5, 1'b0);
        tick();
        cmd_valido[1] = 1'b0;
        chk("t4_second_ocupado", ocupado[1], 1);
        exp_sel[1] = 4'd6; exp_a[1] = 4'd4; exp_b[1] = 4'd9;
        chk_alu(1, "t4_second");
        wait_rsp(1, 3);
        r = alu_ref(4'd6, 4'd4, 4'd9);
        check_rsp(1, 4'd13, r[W+3:W], 1'b0, 0, 1'b0);
        exp_acc[1] = 4'd13;

        // Reset during the second wait cycle.
        cmd_valido[1] = 1'b1;
        cmd_sel[1] = 4'd2; cmd_a[1] = 4'd3; cmd_b[1] = 4'd3;
        tick();
        cmd_valido[1] = 1'b0;
        tick();
        reset[1] = 1'b1;
        #1;
        chk_reset(1);
        exp_sel[1] = '0; exp_a[1] = '0; exp_b[1] = '0; exp_acc[1] = '0;
        tick();
        reset[1] = 1'b0;
        tick();
        chk("t5_cmd_listo", cmd_listo[1], 1);
        run_cmd(1, 4'd2, 4'd3, 4'd3, 1'b0, 0, 1'b0);
        chk("t5_res", rsp_res[1], 9);

        for (int i = 0; i < 60; i++) begin
            int           d;
            logic [3:0]   s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            bit           usa;
            d   = i % 2;
            s   = 4'($urandom_range(0, 15));
            a   = W'($urandom_range(0, 15));
            b   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
            usa = 1'b0;
`ifdef ALU_ACUMULADOR_EN
            usa = 1'($urandom_range(0, 1));
`endif
            run_cmd(d, s, a, b, usa, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef ALU_ACUMULADOR_EN
        run_cmd(0, 4'd0, 4'd2, 4'd3, 1'b0, 0, 1'b0);
        chk("t6_first_res", rsp_res[0], 5);
        run_cmd(0, 4'd0, 4'd0, 4'd1, 1'b1, 0, 1'b0);
        chk("t6_alu_a", alu_a[0], 5);
        chk("t6_res", rsp_res[0], 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
